// File: rtl/entrada_timer_controle_pkg.sv
// Shared constants, key-code type and keypad priority encoder for the cooking-timer input front end.
package entrada_timer_controle_pkg;

    localparam int KEY_W           = 4;
    localparam int NUM_KEYS        = 10;
    localparam int CLK_DIV_DEFAULT = 100;

    typedef logic [KEY_W-1:0] key_code_t;

    localparam key_code_t NO_KEY = 4'hF;

    // Highest pressed key wins; an idle keypad maps to NO_KEY.
    function automatic key_code_t encode_key(input logic [NUM_KEYS-1:0] keys);
        key_code_t code;
        code = NO_KEY;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keys[i]) begin
                code = KEY_W'(i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/entrada_timer_controle_div_1hz.sv
// Free-running divider: counts 0..CLK_DIV-1 and drives a registered 50% duty pgt output.
module entrada_timer_controle_div_1hz
    import entrada_timer_controle_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic pgt_o
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          pgt_q;
    logic          pgt_d;

    // pgt is derived from the next count so it rises CLK_DIV/2 edges after reset.
    always_comb begin
        if (count_q == CW'(CLK_DIV - 1)) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
        pgt_d = (count_d >= CW'(CLK_DIV / 2));
    end

    // Divider state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            pgt_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pgt_q   <= pgt_d;
        end
    end

    assign pgt_o = pgt_q;

endmodule

// File: rtl/entrada_timer_controle.sv
// Keypad encoder, load-strobe generator and 1 Hz timebase. Optional input filter: KEYPAD_DEBOUNCE_EN.
module entrada_timer_controle
    import entrada_timer_controle_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int DEB_CYCLES = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [NUM_KEYS-1:0] Teclado,
    input  logic                enableN,
    output logic [KEY_W-1:0]    D,
    output logic                loadN,
    output logic                pgt_1Hz
);

    key_code_t raw_code_s;
    key_code_t cur_code_s;
    key_code_t prev_code_q;
    key_code_t d_q;
    key_code_t d_d;
    logic      loadn_q;
    logic      loadn_d;

    assign raw_code_s = encode_key(Teclado);

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);

    key_code_t      cand_q;
    key_code_t      stable_q;
    logic [DW-1:0]  deb_cnt_q;
    logic [DW-1:0]  deb_eff_s;

    // A code becomes current on the DEB_CYCLES-th identical consecutive sample.
    always_comb begin
        if (raw_code_s == cand_q) begin
            if (deb_cnt_q == DW'(DEB_CYCLES)) begin
                deb_eff_s = deb_cnt_q;
            end else begin
                deb_eff_s = deb_cnt_q + DW'(1);
            end
        end else begin
            deb_eff_s = DW'(1);
        end
        if (deb_eff_s >= DW'(DEB_CYCLES)) begin
            cur_code_s = raw_code_s;
        end else begin
            cur_code_s = stable_q;
        end
    end

    // Debounce filter state.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cand_q    <= NO_KEY;
            stable_q  <= NO_KEY;
            deb_cnt_q <= '0;
        end else begin
            cand_q    <= raw_code_s;
            stable_q  <= cur_code_s;
            deb_cnt_q <= deb_eff_s;
        end
    end
`else
    assign cur_code_s = raw_code_s;

    if (DEB_CYCLES < 1) begin : g_deb_cycles_invalid
    end
`endif

    // Accept a valid key only on the edge where its code first appears.
    always_comb begin
        d_d     = d_q;
        loadn_d = 1'b1;
        if (!enableN && (cur_code_s != NO_KEY) && (cur_code_s != prev_code_q)) begin
            d_d     = cur_code_s;
            loadn_d = 1'b0;
        end else begin
            d_d     = d_q;
            loadn_d = 1'b1;
        end
    end

    // Strobe, digit and previous-code registers; the previous code tracks even while disabled.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            prev_code_q <= NO_KEY;
            d_q         <= 4'd0;
            loadn_q     <= 1'b1;
        end else begin
            prev_code_q <= cur_code_s;
            d_q         <= d_d;
            loadn_q     <= loadn_d;
        end
    end

    entrada_timer_controle_div_1hz #(
        .CLK_DIV (CLK_DIV)
    ) u_div_1hz (
        .clk_i (Clock),
        .rst_i (Reset),
        .pgt_o (pgt_1Hz)
    );

    assign D     = d_q;
    assign loadN = loadn_q;

endmodule

// File: tb/tb_entrada_timer_controle.sv
// Randomised self-checking bench for entrada_timer_controle against a behavioural model.
module tb_entrada_timer_controle;

    localparam int CLK_DIV = 100;

    logic       Clock;
    logic       Reset;
    logic [9:0] Teclado;
    logic       enableN;
    logic [3:0] D;
    logic       loadN;
    logic       pgt_1Hz;

    int pass_cnt  = 0;
    int total_cnt = 0;

    entrada_timer_controle #(
        .CLK_DIV    (CLK_DIV),
        .DEB_CYCLES (2)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Teclado (Teclado),
        .enableN (enableN),
        .D       (D),
        .loadN   (loadN),
        .pgt_1Hz (pgt_1Hz)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Model state: key index (-1 = none), outputs, and edges since reset.
    int   m_prev;
    int   m_d;
    logic m_loadn;
    int   m_edges;
    bit   chk_en = 1'b0;
    bit   rise_checked = 1'b0;
    logic pgt_last = 1'b0;

    function automatic int key_of(input logic [9:0] k);
        for (int i = 9; i >= 0; i--) begin
            if (k[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(posedge Clock or posedge Reset) begin
        int code;
        if (Reset) begin
            m_prev  = -1;
            m_d     = 0;
            m_loadn = 1'b1;
            m_edges = 0;
        end else begin
            code    = key_of(Teclado);
            m_loadn = 1'b1;
            if (!enableN && code >= 0 && code != m_prev) begin
                m_d     = code;
                m_loadn = 1'b0;
            end
            m_prev  = code;
            m_edges = m_edges + 1;
        end
    end

    always @(negedge Clock) begin
        if (chk_en) begin
            check("D", int'(D), m_d);
            check("loadN", int'(loadN), int'(m_loadn));
            check("pgt_1Hz", int'(pgt_1Hz), ((m_edges % CLK_DIV) >= CLK_DIV / 2) ? 1 : 0);
            if (!rise_checked && pgt_1Hz && !pgt_last) begin
                check("first_pgt_rise_edges", m_edges, 50);
                rise_checked = 1'b1;
            end
            pgt_last = pgt_1Hz;
        end
    end

    task automatic run(input int cyc, input logic [9:0] tec, input logic en, output int pulses);
        Teclado = tec;
        enableN = en;
        pulses  = 0;
        repeat (cyc) begin
            @(negedge Clock);
            if (loadN == 1'b0) pulses++;
        end
    endtask

    initial begin
        int p;
        logic [9:0] tec;
        Reset   = 1'b1;
        Teclado = 10'd0;
        enableN = 1'b1;
        chk_en  = 1'b1;
        repeat (3) @(negedge Clock);
        check("reset_D", int'(D), 0);
        check("reset_loadN", int'(loadN), 1);
        check("reset_pgt", int'(pgt_1Hz), 0);
        Reset = 1'b0;

        run(10, 10'b0001000000, 1'b0, p);
        check("key6_pulses", p, 1);
        check("key6_D", int'(D), 6);
        run(10, 10'b0000000000, 1'b0, p);
        check("release_pulses", p, 0);
        run(10, 10'b0000000001, 1'b0, p);
        check("key0_pulses", p, 1);
        check("key0_D", int'(D), 0);
        run(10, 10'b1000001000, 1'b0, p);
        check("key9_pulses", p, 1);
        check("key9_D", int'(D), 9);
        run(10, 10'b0001000000, 1'b1, p);
        check("dis6_pulses", p, 0);
        run(10, 10'b0000000001, 1'b1, p);
        check("dis0_pulses", p, 0);
        run(10, 10'b1000001000, 1'b1, p);
        check("dis9_pulses", p, 0);
        check("dis_D", int'(D), 9);
        run(150, 10'b1000001000, 1'b1, p);
        check("dis_hold_pulses", p, 0);
        // Key held while enable falls: no load until it changes.
        run(5, 10'b1000001000, 1'b0, p);
        check("held_enable_pulses", p, 0);

        tec = 10'd0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge Clock);
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0:       tec = 10'd0;
                    1, 2:    tec = 10'd1 << $urandom_range(0, 9);
                    default: tec = 10'($urandom_range(0, 1023));
                endcase
            end
            Teclado = tec;
            if ($urandom_range(0, 9) == 0) enableN = ~enableN;
            if (c == 1500) begin
                #1 Reset = 1'b1;
                #1;
                check("midreset_D", int'(D), 0);
                check("midreset_loadN", int'(loadN), 1);
                check("midreset_pgt", int'(pgt_1Hz), 0);
                repeat (2) @(negedge Clock);
                Reset = 1'b0;
            end
        end

        check("pgt_rise_seen", int'(rise_checked), 1);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
